// File: rtl/sprite_pkg.sv
// Shared constants for the sprite scanline fetcher: transparent key colour,
// default sprite geometry and the FSM state encodings.
package sprite_pkg;
  localparam logic [23:0] TRANSPARENT  = 24'hFF00FF;
  localparam int          DEF_SPRITE_W = 16;
  localparam int          DEF_SPRITE_H = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/sprite_hit.sv
// Combinational row/visibility test for one sprite descriptor against a scanline.
module sprite_hit import sprite_pkg::*; #(
  parameter int YW       = 10,
  parameter int SPRITE_H = DEF_SPRITE_H
) (
  input  logic [YW-1:0] i_line_y,
  input  logic [YW-1:0] i_spr_y,
  input  logic          i_en,
  output logic          o_hit,
  output logic [YW-1:0] o_row
);
  assign o_row = i_line_y - i_spr_y;
  assign o_hit = i_en && (i_line_y >= i_spr_y) && (o_row < YW'(SPRITE_H));
endmodule

// File: rtl/sprite_line_fetch.sv
// Walks the sprite list during hblank, reads the active row of each visible
// sprite from image memory and writes opaque pixels into the line buffer.
module sprite_line_fetch import sprite_pkg::*; #(
  parameter int WORD_SIZE = 24,
  parameter int ADDR_W    = 12,
  parameter int SPRITE_W  = DEF_SPRITE_W,
  parameter int SPRITE_H  = DEF_SPRITE_H,
  parameter int N_SPRITES = 4,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int LINE_W    = 640
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_line_start,
  input  logic [YW-1:0]              i_line_y,
  input  logic [N_SPRITES-1:0]       i_spr_en,
  input  logic [N_SPRITES*XW-1:0]    i_spr_x,
  input  logic [N_SPRITES*YW-1:0]    i_spr_y,
  input  logic [N_SPRITES*ADDR_W-1:0] i_spr_base,
  output logic [ADDR_W-1:0]          o_mem_addr,
  input  logic [WORD_SIZE-1:0]       i_mem_dout,
  output logic                       o_lb_we,
  output logic [XW-1:0]              o_lb_addr,
  output logic [WORD_SIZE-1:0]       o_lb_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overrun
);
  localparam int IW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SPRITES - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(SPRITE_W - 1);
  localparam logic [XW:0]   LINE_LIM = (XW+1)'(LINE_W);

  logic [2:0]        r_state;
  logic [YW-1:0]     r_line_y;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_col;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_valid;
  logic [XW:0]       r_x;

  logic [YW-1:0]     w_spr_y;
  logic [XW-1:0]     w_spr_x;
  logic [ADDR_W-1:0] w_spr_base;
  logic              w_hit;
  logic [YW-1:0]     w_row;
  logic [ADDR_W-1:0] w_row_off;
  logic [XW:0]       w_x_sum;

  // Descriptors are read live through the current index.
  assign w_spr_y    = i_spr_y[r_idx*YW +: YW];
  assign w_spr_x    = i_spr_x[r_idx*XW +: XW];
  assign w_spr_base = i_spr_base[r_idx*ADDR_W +: ADDR_W];
  assign w_row_off  = ADDR_W'(w_row) * ADDR_W'(SPRITE_W);
  assign w_x_sum    = {1'b0, w_spr_x} + (XW+1)'(r_col);

  sprite_hit #(.YW(YW), .SPRITE_H(SPRITE_H)) u_hit (
    .i_line_y (r_line_y),
    .i_spr_y  (w_spr_y),
    .i_en     (i_spr_en[r_idx]),
    .o_hit    (w_hit),
    .o_row    (w_row)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_line_y   <= '0;
      r_idx      <= '0;
      r_col      <= '0;
      r_mem_addr <= '0;
      r_valid    <= 1'b0;
      r_x        <= '0;
    end else begin
      r_valid <= (r_state == S_FETCH);
      if (r_state == S_FETCH) r_x <= w_x_sum;
      case (r_state)
        S_IDLE: if (i_line_start) begin
          r_line_y <= i_line_y;
          r_idx    <= '0;
          r_state  <= S_CHECK;
        end
        S_CHECK: if (w_hit) begin
          r_mem_addr <= w_spr_base + w_row_off;
          r_col      <= '0;
          r_state    <= S_FETCH;
        end else if (r_idx == LAST_IDX) begin
          r_state <= S_DONE;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
        S_FETCH: begin
          r_col <= r_col + 1'b1;
          // Address stays on the last word so it holds outside FETCH.
          if (r_col == LAST_COL) r_state <= S_DRAIN;
          else                   r_mem_addr <= r_mem_addr + 1'b1;
        end
        S_DRAIN: if (r_idx == LAST_IDX) begin
          r_state <= S_DONE;
        end else begin
          r_idx   <= r_idx + 1'b1;
          r_state <= S_CHECK;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_lb_we    = r_valid && (i_mem_dout != WORD_SIZE'(TRANSPARENT)) && (r_x < LINE_LIM);
  assign o_lb_addr  = r_x[XW-1:0];
  assign o_lb_data  = i_mem_dout;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_overrun  = i_line_start && o_busy;
endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a 1-cycle image memory model.
module tb_sprite_line_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic [3:0]  spr_en = '0;
  logic [39:0] spr_x = '0;
  logic [39:0] spr_y = '0;
  logic [47:0] spr_base = '0;
  logic [11:0] mem_addr;
  logic [23:0] mem_dout;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [23:0] lb_data;
  logic        busy, done, overrun;

  logic [23:0] mem [0:4095];
  logic [23:0] lb  [0:1023];
  logic [11:0] addr_log [0:127];
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int dcyc;

  sprite_line_fetch dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_line_start(line_start), .i_line_y(line_y),
    .i_spr_en(spr_en), .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_base(spr_base),
    .o_mem_addr(mem_addr), .i_mem_dout(mem_dout), .o_lb_we(lb_we), .o_lb_addr(lb_addr),
    .o_lb_data(lb_data), .o_busy(busy), .o_done(done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_dout <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic samp(input int c);
    if (c < 128) addr_log[c] = mem_addr;
    if (lb_we) begin
      lb[lb_addr] = lb_data;
      wr_cnt++;
    end
  endtask

  task automatic clear_lb();
    for (int i = 0; i < 1024; i++) lb[i] = '0;
    wr_cnt = 0;
  endtask

  // Pulse line_start in cycle 0, return the cycle in which done is seen.
  task automatic run_line(input logic [9:0] y, output int c);
    clear_lb();
    @(negedge clk);
    samp(0);
    line_start = 1'b1;
    line_y = y;
    @(negedge clk);
    line_start = 1'b0;
    c = 1;
    samp(c);
    while (!done && c < 120) begin
      @(negedge clk);
      c++;
      samp(c);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = {12'h123, a[11:0]};
    mem[12'h073] = 24'hFF00FF;
    mem[12'h077] = 24'hFF00FF;
    spr_en = 4'b0001;
    spr_x[0 +: 10] = 10'd100;
    spr_y[0 +: 10] = 10'd10;
    spr_base[0 +: 12] = 12'h040;

    #12;
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_lb_we",    lb_we,    32'h0);
    chk("rst_lb_addr",  lb_addr,  32'h0);
    chk("rst_busy",     busy,     32'h0);
    chk("rst_done",     done,     32'h0);
    chk("rst_overrun",  overrun,  32'h0);
    reset_n = 1'b1;

    // Single sprite, row 2
    run_line(10'd12, dcyc);
    chk("single_done_cyc", dcyc, 22);
    chk("single_addr_c2",  addr_log[2],  32'h060);
    chk("single_addr_c17", addr_log[17], 32'h06F);
    chk("single_wr_cnt",   wr_cnt, 16);
    chk("single_lb100",    lb[100], 32'h123060);
    chk("single_lb115",    lb[115], 32'h12306F);
    chk("single_lb116",    lb[116], 32'h0);
    chk("single_addr_hold", mem_addr, 32'h06F);

    // Transparency, row 3 has key colour at cols 3 and 7
    run_line(10'd13, dcyc);
    chk("transp_done_cyc", dcyc, 22);
    chk("transp_wr_cnt",   wr_cnt, 14);
    chk("transp_lb103",    lb[103], 32'h0);
    chk("transp_lb107",    lb[107], 32'h0);
    chk("transp_lb104",    lb[104], 32'h123074);

    // Right-edge clip
    spr_x[0 +: 10] = 10'd630;
    run_line(10'd12, dcyc);
    chk("clip_done_cyc", dcyc, 22);
    chk("clip_wr_cnt",   wr_cnt, 10);
    chk("clip_lb639",    lb[639], 32'h123069);
    chk("clip_lb640",    lb[640], 32'h0);
    chk("clip_addr_c17", addr_log[17], 32'h06F);

    // Overlap, sprite 1 on top
    spr_en = 4'b0011;
    spr_x[0 +: 10] = 10'd200;
    spr_x[10 +: 10] = 10'd200;
    spr_y[10 +: 10] = 10'd10;
    spr_base[12 +: 12] = 12'h200;
    run_line(10'd12, dcyc);
    chk("ovl_done_cyc", dcyc, 39);
    chk("ovl_wr_cnt",   wr_cnt, 32);
    chk("ovl_lb200",    lb[200], 32'h123220);
    chk("ovl_lb215",    lb[215], 32'h12322F);
    chk("ovl_addr_c20", addr_log[20], 32'h220);

    // Misses above and below, plus last row boundary
    spr_en = 4'b0001;
    spr_x[0 +: 10] = 10'd100;
    spr_y[0 +: 10] = 10'd20;
    run_line(10'd19, dcyc);
    chk("miss_above_done", dcyc, 5);
    chk("miss_above_wr",   wr_cnt, 0);
    run_line(10'd36, dcyc);
    chk("miss_below_done", dcyc, 5);
    chk("miss_below_wr",   wr_cnt, 0);
    run_line(10'd35, dcyc);
    chk("lastrow_done",  dcyc, 22);
    chk("lastrow_lb100", lb[100], 32'h123130);

    // line_start during DONE cycle counts as overrun
    @(negedge clk);
    line_start = 1'b1;
    line_y = 10'd19;
    @(negedge clk);
    line_start = 1'b0;
    repeat (4) @(negedge clk);
    line_start = 1'b1;
    #1;
    chk("done_cyc_done",    done,    32'h1);
    chk("done_cyc_overrun", overrun, 32'h1);
    @(negedge clk);
    line_start = 1'b0;
    #1;
    chk("done_cyc_no_restart", busy, 32'h0);

    // Overrun mid-fetch, then asynchronous reset
    spr_y[0 +: 10] = 10'd10;
    clear_lb();
    @(negedge clk);
    line_start = 1'b1;
    line_y = 10'd12;
    @(negedge clk);
    line_start = 1'b0;
    repeat (7) @(negedge clk);
    line_start = 1'b1;
    #1;
    chk("ovr_pulse", overrun, 32'h1);
    chk("ovr_busy",  busy,    32'h1);
    @(negedge clk);
    line_start = 1'b0;
    #1;
    chk("ovr_pulse_end", overrun, 32'h0);
    chk("ovr_no_restart_addr", mem_addr, 32'h067);
    @(negedge clk);
    chk("pre_rst_lb_we", lb_we, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_lb_we",    lb_we,    32'h0);
    chk("rst_mid_busy",     busy,     32'h0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      samp(0);
    end
    chk("rst_no_writes", wr_cnt, 0);
    run_line(10'd12, dcyc);
    chk("post_rst_done", dcyc, 22);
    chk("post_rst_wr",   wr_cnt, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Per-scanline sprite fetcher sitting directly downstream of the sprite image memory. During horizontal blanking it walks the sprite descriptor list, reads the active row of every sprite that intersects the requested line from image memory, and writes the non-transparent 24-bit RGB pixels into the scanline buffer consumed by the VGA output stage. Later sprites overwrite earlier ones, so sprite N_SPRITES-1 is on top.

## Interface
- WORD_SIZE, 24: pixel width (RGB888), matches image memory word.
- ADDR_W, 12: image memory address width.
- SPRITE_W, 16: sprite width in pixels; power of two.
- SPRITE_H, 16: sprite height in lines.
- N_SPRITES, 4: descriptor count.
- XW, 10 / YW, 10: screen coordinate widths.
- LINE_W, 640: visible pixels per line; clip limit.
- Clocking (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse; begin fetch for line_y.
- line_y  in  YW  target scanline; sampled with line_start.
- spr_en  in  N_SPRITES  per-sprite enable.
- spr_x  in  N_SPRITES*XW  sprite left x, sprite i at [i*XW +: XW].
- spr_y  in  N_SPRITES*YW  sprite top y.
- spr_base  in  N_SPRITES*ADDR_W  image memory word address of sprite pixel (0,0).
- mem_addr  out  ADDR_W  image memory read address.
- mem_dout  in  WORD_SIZE  image memory data; valid the cycle after mem_addr is presented.
- lb_we  out  1  line buffer write strobe.
- lb_addr  out  XW  line buffer x.
- lb_data  out  WORD_SIZE  pixel; equals mem_dout.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, line complete.
- overrun  out  1  one-cycle pulse, line_start arrived while busy.

## Operation
- States: IDLE, CHECK, FETCH, DRAIN, DONE.
- IDLE: on line_start latch line_y, idx=0 -> CHECK.
- CHECK: row = line_y - spr_y[idx] (YW bits). Hit iff spr_en[idx] and line_y >= spr_y[idx] and row < SPRITE_H. Hit: base_q = spr_base[idx] + row*SPRITE_W (mod 2^ADDR_W), col=0 -> FETCH. Miss: idx==N_SPRITES-1 -> DONE, else idx+1, stay CHECK.
- FETCH: mem_addr = base_q + col; pipeline reg captures x = spr_x[idx] + col (XW+1 bits), valid=1; col++. After col SPRITE_W-1 issued -> DRAIN.
- DRAIN: last pixel written; then DONE if last idx else idx+1 -> CHECK.
- DONE: done=1 for one cycle -> IDLE.
- Write path (combinational from pipeline reg and mem_dout): lb_we = valid_q && mem_dout != TRANSPARENT && x_q < LINE_W; lb_addr = x_q[XW-1:0].
- Descriptor inputs are read live; the register file holds them stable while busy.
- line_start while busy: ignored, overrun pulses that cycle.
- mem_addr outside FETCH: holds last value; no side effects (read-only).

## Timing
- Reset values: state IDLE, mem_addr 0, lb_we 0, lb_addr 0, busy 0, done 0, overrun 0; lb_data don't-care while lb_we=0.
- Read latency 1: address in cycle k, lb write in cycle k+1.
- With line_start at cycle 0: done at cycle 1 + N_SPRITES + V*(SPRITE_W+1), V = hit count. Worst case default params: 73 cycles, well inside hblank.
- Reset mid-operation: lb_we drops asynchronously, FSM to IDLE, no further writes; fetch not resumed.
- line_start in the DONE cycle counts as busy (overrun).

## Structure
- sprite_pkg: TRANSPARENT = 24'hFF00FF, state enum, default SPRITE_W/SPRITE_H.
- Sub-module sprite_hit: combinational row/visibility check (line_y, spr_y, spr_en -> hit, row); used by CHECK.

## Test plan
- Single sprite: idx0 en, spr_y=10, line_y=12, spr_x=100, base=0x040 -> mem_addr 0x060..0x06F cycles 2..17, lb writes x 100..115, done at cycle 22.
- Transparency: words 3 and 7 of row = 24'hFF00FF -> no lb_we at x 103, 107; other 14 written.
- Clip: spr_x=630 -> writes x 630..639 only, 16 reads still issued, done unchanged.
- Overlap: sprites 0 and 1 both at x=200, same line -> sprite 1 writes each x after sprite 0; final buffer holds sprite 1 pixels; done at cycle 39.
- Miss: spr_y=20, line_y=19 then 36 -> no reads, no writes, done at cycle 5.
- line_start at cycle 8 while busy -> overrun pulse, no restart; reset_n low at cycle 10 -> lb_we and busy 0 immediately, next line_start runs normally.
